mux8_seq: RTL and testbench
===========================

MUX8_SEQ -- requirements
Module: mux8_seq

Interface
REQ-001 Parameter N_IN, default 8, number of mux data inputs scanned; fixed at 8 in this revision.
REQ-002 Parameter SEL_W, default 3, select width, equal to log2(N_IN).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request one scan of all mux inputs; sampled in IDLE only.
REQ-006 abort  input  1  terminate an in-progress scan.
REQ-007 F  input  1  combinational output of the downstream mux8 for the current select.
REQ-008 s0  output  1  mux select bit 0 (LSB).
REQ-009 s1  output  1  mux select bit 1.
REQ-010 s2  output  1  mux select bit 2 (MSB).
REQ-011 busy  output  1  high while in SCAN.
REQ-012 done  output  1  one-cycle pulse when data_out is updated.
REQ-013 data_out  output  8  captured word; bit i equals F sampled with select i.
REQ-014 parity  output  1  present only with MUX8_SEQ_PARITY_EN (see Configuration).

Function
REQ-015 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-016 IDLE: {s2,s1,s0}=0, busy=0, done=0; start=1 -> SCAN with index=0 on the next cycle.
REQ-017 SCAN: {s2,s1,s0} SHALL equal the registered index; busy=1.
REQ-018 Each SCAN cycle SHALL capture F into shadow[index] at the clock edge, then increment index.
REQ-019 When index=7 is captured, the next state SHALL be DONE and index SHALL wrap to 0.
REQ-020 DONE: data_out SHALL load all 8 shadow bits atomically, done=1 for exactly one cycle, then IDLE.
REQ-021 Latency: start high at edge 0 -> SCAN cycles 1..8 -> done high in cycle 9 -> IDLE in cycle 10.
REQ-022 start SHALL be ignored in SCAN and DONE; a back-to-back scan needs start in IDLE (period 10 cycles).
REQ-023 abort=1 in SCAN SHALL go to IDLE next cycle, with no done pulse and data_out unchanged.
REQ-024 abort and start both high in IDLE SHALL start the scan; abort only acts in SCAN.
REQ-025 abort in the cycle that captures index 7 SHALL take precedence: IDLE, no DONE.
REQ-026 data_out SHALL hold its value between done pulses.

Reset
REQ-027 rst=1 SHALL force IDLE, index=0, shadow=0, data_out=0, selects=0, busy=0, done=0, parity=0.
REQ-028 rst during SCAN or DONE SHALL discard the scan, and no done pulse SHALL follow.
REQ-029 rst SHALL override start and abort.

Configuration
REQ-030 With MUX8_SEQ_PARITY_EN defined, the parity port SHALL exist and load XOR-reduce(shadow) in the same cycle data_out loads; its reset value is 0.
REQ-031 Without MUX8_SEQ_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared package mux8_seq_pkg SHALL hold N_IN, SEL_W and the state encoding (IDLE=2'b00, SCAN=2'b01, DONE=2'b10).
REQ-033 The index counter SHALL be a sub-module sel_counter: 3-bit, with synchronous clear, enable and a terminal-count flag at 7.

Verification
REQ-034 The bench SHALL instantiate the existing mux8 with D7..D0 = 8'hA5, its F wired to mux8_seq and the selects wired back. Stimulus: pulse start. Required: selects step 0..7 in cycles 1..8, done in cycle 9, data_out=8'hA5.
REQ-035 D=8'h3C, start, then abort in cycle 4. Required: IDLE in cycle 5, no done, data_out keeps its previous value 8'hA5.
REQ-036 D=8'hFF, start held high continuously. Required: scans begin every 10 cycles and each yields data_out=8'hFF.
REQ-037 rst asserted in cycle 6 of a scan with D=8'h0F. Required: all outputs 0 next cycle and no done pulse.
REQ-038 With MUX8_SEQ_PARITY_EN defined: D=8'h07 gives parity=1 and D=8'h03 gives parity=0, each with done. Without the macro, the build SHALL have no parity port.
REQ-039 abort asserted in the index-7 capture cycle. Required: no done pulse and data_out unchanged.

Source files
------------

// File: rtl/mux8_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_seq_pkg
//  Description : Shared constants and FSM state encoding for the mux8_seq
//                scanner.
//                  N_IN  - number of mux data inputs scanned
//                  SEL_W - select width (log2 of N_IN)
//                  state_e - IDLE / SCAN / DONE encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package mux8_seq_pkg;

   localparam int N_IN  = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage : mux8_seq_pkg
`default_nettype wire

// File: rtl/mux8_seq_sel_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sel_counter
//  Description : Free-wrapping select index counter for the mux8 scanner.
//  Ports       : clk      - clock, rising edge
//                clr_i    - synchronous clear to zero (wins over en_i)
//                en_i     - increment enable
//                count_o  - current index
//                tc_o     - terminal count, high when count_o is all ones
//  Revision    : 1.0 - initial release
// ============================================================================
module sel_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic         tc_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         // Natural overflow wraps the all-ones index back to zero.
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count_o = count_q;
   assign tc_o    = &count_q;

endmodule : sel_counter
`default_nettype wire

// File: rtl/mux8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_seq
//  Description : Sequential scanner for an external 8:1 mux. Steps the mux
//                select through all inputs, samples the mux output F at each
//                select and publishes the captured word atomically with a
//                one-cycle done pulse.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                start     - request one scan (honoured in IDLE only)
//                abort     - terminate an in-progress scan
//                F         - mux output for the current select
//                s0/s1/s2  - mux select, LSB..MSB
//                busy      - high while scanning
//                done      - one-cycle pulse when data_out updates
//                data_out  - captured word, bit i = F at select i
//                parity    - XOR of captured word (MUX8_SEQ_PARITY_EN only)
//  Options     : MUX8_SEQ_PARITY_EN - adds the parity output and register
//  Revision    : 1.0 - initial release
// ============================================================================
module mux8_seq #(
   parameter int N_IN  = mux8_seq_pkg::N_IN,
   parameter int SEL_W = mux8_seq_pkg::SEL_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            F,
   output logic            s0,
   output logic            s1,
   output logic            s2,
   output logic            busy,
   output logic            done,
   output logic [N_IN-1:0] data_out
`ifdef MUX8_SEQ_PARITY_EN
   ,
   output logic            parity
`endif
);

   import mux8_seq_pkg::*;

   state_e            state_q;
   state_e            state_d;
   logic [N_IN-1:0]   shadow_q;
   logic [N_IN-1:0]   shadow_d;
   logic [N_IN-1:0]   data_out_q;
   logic [SEL_W-1:0]  idx;
   logic              idx_tc;
   logic              capture;
   logic              publish;
   logic [SEL_W-1:0]  sel;

   // Index is held at zero outside SCAN so every scan starts at input 0;
   // an abort also clears it so a later scan starts clean.
   sel_counter #(
      .W (SEL_W)
   ) u_sel_counter (
      .clk     (clk),
      .clr_i   (rst || (state_q != SCAN) || abort),
      .en_i    (state_q == SCAN),
      .count_o (idx),
      .tc_o    (idx_tc)
   );

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = SCAN;
         SCAN: begin
            if (abort)       state_d = IDLE;   // abort beats the final capture
            else if (idx_tc) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An aborted cycle captures nothing; the partial word is never published.
   assign capture = (state_q == SCAN) && !abort;
   assign publish = capture && idx_tc;

   // Shadow with the current F merged in, so the word published on the
   // last capture already contains bit N_IN-1.
   always_comb begin
      shadow_d = shadow_q;
      if (capture) begin
         shadow_d[idx] = F;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         data_out_q <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         if (publish) begin
            data_out_q <= shadow_d;
         end
      end
   end

`ifdef MUX8_SEQ_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (publish) begin
         parity_q <= ^shadow_d;
      end
   end

   assign parity = parity_q;
`endif

   // ------------------------------------------------------------ outputs
   // data_out is loaded on the edge entering DONE, so it is valid in the
   // same cycle the done pulse is visible.
   assign sel      = (state_q == SCAN) ? idx : '0;
   assign s0       = sel[0];
   assign s1       = sel[1];
   assign s2       = sel[2];
   assign busy     = (state_q == SCAN);
   assign done     = (state_q == DONE);
   assign data_out = data_out_q;

endmodule : mux8_seq
`default_nettype wire

// File: tb/tb_mux8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux8_seq
//  Description : Directed self-checking bench for mux8_seq. A behavioural
//                8:1 mux driven by D is closed around the scanner.
//  Options     : MUX8_SEQ_PARITY_EN - also checks the parity output
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] D;
   logic       F;
   logic       s0, s1, s2;
   logic       busy;
   logic       done;
   logic [7:0] data_out;
   logic [2:0] sel;
`ifdef MUX8_SEQ_PARITY_EN
   logic       parity;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   mux8_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .F        (F),
      .s0       (s0),
      .s1       (s1),
      .s2       (s2),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
`ifdef MUX8_SEQ_PARITY_EN
      ,
      .parity   (parity)
`endif
   );

   // Downstream mux8 model: F follows the selected data input.
   assign sel = {s2, s1, s0};
   assign F   = D[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full scan of word d from IDLE, checking every cycle of the sequence.
   task automatic scan(input logic [7:0] d, input logic exp_par);
      D     = d;
      start = 1'b1;
      step();                                   // edge 0
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin         // cycles 1..8
         check("scan_sel",  32'(sel),  32'(k));
         check("scan_busy", 32'(busy), 32'd1);
         check("scan_done", 32'(done), 32'd0);
         step();
      end
      check("done_pulse", 32'(done),     32'd1); // cycle 9
      check("done_data",  32'(data_out), 32'(d));
`ifdef MUX8_SEQ_PARITY_EN
      check("done_parity", 32'(parity), 32'(exp_par));
`else
      if (exp_par !== ^d) $display("note: parity argument unused in this build");
`endif
      step();                                    // cycle 10
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_data", 32'(data_out), 32'(d));
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      D     = 8'h00;
      step();
      step();

      // Reset state
      check("rst_sel",  32'(sel),      32'd0);
      check("rst_busy", 32'(busy),     32'd0);
      check("rst_done", 32'(done),     32'd0);
      check("rst_data", 32'(data_out), 32'd0);
`ifdef MUX8_SEQ_PARITY_EN
      check("rst_parity", 32'(parity), 32'd0);
`endif
      rst = 1'b0;
      step();

      // Basic scan of 8'hA5
      scan(8'hA5, 1'b0);

      // Abort in cycle 4 of a scan of 8'h3C
      D     = 8'h3C;
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();                     // now in cycle 4
      check("abort_c4_sel", 32'(sel), 32'd3);
      abort = 1'b1;
      step();                                     // cycle 5
      abort = 1'b0;
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_idle_sel",  32'(sel),  32'd0);
      for (int k = 0; k < 8; k++) begin
         check("abort_no_done", 32'(done), 32'd0);
         step();
      end
      check("abort_keep_data", 32'(data_out), 32'hA5);

      // start held high: back-to-back scans every 10 cycles
      D     = 8'hFF;
      start = 1'b1;
      step();                                     // edge 0
      for (int s = 0; s < 3; s++) begin
         for (int c = 1; c <= 8; c++) begin
            check("b2b_sel",  32'(sel),  32'(c - 1));
            check("b2b_busy", 32'(busy), 32'd1);
            step();
         end
         check("b2b_done", 32'(done),     32'd1);
         check("b2b_data", 32'(data_out), 32'hFF);
         step();                                  // cycle 10: IDLE despite start
         check("b2b_idle", 32'(busy), 32'd0);
         check("b2b_idle_done", 32'(done), 32'd0);
         step();                                  // next scan cycle 1
      end
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("b2b_abort_idle", 32'(busy), 32'd0);
      check("b2b_keep_data", 32'(data_out), 32'hFF);

      // Reset in cycle 6 of a scan of 8'h0F
      D     = 8'h0F;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 5; c++) step();       // now in cycle 6
      check("rst6_sel", 32'(sel), 32'd5);
      rst = 1'b1;
      step();
      check("rst6_sel0",  32'(sel),      32'd0);
      check("rst6_busy",  32'(busy),     32'd0);
      check("rst6_done",  32'(done),     32'd0);
      check("rst6_data",  32'(data_out), 32'd0);
`ifdef MUX8_SEQ_PARITY_EN
      check("rst6_parity", 32'(parity), 32'd0);
`endif
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("rst6_no_done", 32'(done), 32'd0);
         step();
      end

      // Parity cases (data checked in every build)
      scan(8'h07, 1'b1);
      scan(8'h03, 1'b0);

      // start and abort together in IDLE start a scan; abort in the
      // index-7 capture cycle suppresses DONE.
      D     = 8'h55;
      start = 1'b1;
      abort = 1'b1;
      step();                                     // edge 0
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", 32'(busy), 32'd1);
      for (int c = 1; c <= 7; c++) step();       // now in cycle 8
      check("ab7_sel", 32'(sel), 32'd7);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab7_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
         check("ab7_no_done", 32'(done), 32'd0);
         step();
      end
      check("ab7_keep_data", 32'(data_out), 32'h03);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_mux8_seq
`default_nettype wire
